// File: rtl/load_control.sv
// ---------------------------------------------------------------------------
// load_control
//
// Read side of the load/store datapath. A one-cycle Start from the multicycle
// control unit issues a word read to data memory. The unit waits MEM_LATENCY
// cycles and captures the returned word in an internal MDR. It then extracts
// the word, halfword or byte, sign- or zero-extends it, and presents the
// result on Out together with a one-cycle Done pulse.
//
// Parameter:
//   MEM_LATENCY  cycles from MemRead assertion to valid MemData (1..15)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   Start      one-cycle load request (ignored while Busy)
//   LCControl  size: 00 word, 01 halfword, 10 byte, 11 word
//   LCSigned   1 = sign-extend, 0 = zero-extend (ignored for word)
//   Addr       byte address of the load
//   MemData    read data returned by memory
//   MemRead    memory read strobe
//   MemAddr    word-aligned read address
//   Out        extended load result, held until the next Done
//   Done       one-cycle pulse, Out valid
//   Busy       high while a load is in flight
//   AlignErr   one-cycle pulse on a misaligned request (lane feature only)
//
// Optional feature macro: LOAD_CONTROL_BYTE_LANE_EN
//   Defined: Addr[1:0] selects the little-endian byte/half lane, and
//            misaligned half/word requests raise AlignErr without a read.
//   Undefined: low-lane extraction, AlignErr tied low.
// ---------------------------------------------------------------------------
module load_control #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  LCControl,
    input  logic        LCSigned,
    input  logic [31:0] Addr,
    input  logic [31:0] MemData,
    output logic        MemRead,
    output logic [31:0] MemAddr,
    output logic [31:0] Out,
    output logic        Done,
    output logic        Busy,
    output logic        AlignErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        EXTRACT = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic [3:0]  count;
    logic [31:0] mdr;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  lane_q;
    logic [31:0] extracted;
    logic        misaligned;

`ifdef LOAD_CONTROL_BYTE_LANE_EN
    // Half needs an even address; word (00 or 11) needs a 4-byte aligned one.
    always_comb begin
        misaligned = 1'b0;
        case (LCControl)
            2'b01:   misaligned = Addr[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = (Addr[1:0] != 2'b00);
        endcase
    end
`else
    // Lane bits are not used when extraction is fixed to the low lane.
    logic unused_addr_lane;
    assign unused_addr_lane = ^Addr[1:0];
    assign misaligned       = 1'b0;
`endif

    // Extraction from MDR using the size/sign/lane captured at Start.
    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        lane_byte = 8'(mdr >> {lane_q, 3'b000});
        lane_half = lane_q[1] ? mdr[31:16] : mdr[15:0];
        extracted = mdr;
        case (size_q)
            2'b01:   extracted = {{16{sign_q & lane_half[15]}}, lane_half};
            2'b10:   extracted = {{24{sign_q & lane_byte[7]}}, lane_byte};
            default: extracted = mdr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            mdr      <= 32'd0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            lane_q   <= 2'b00;
            MemRead  <= 1'b0;
            MemAddr  <= 32'd0;
            Out      <= 32'd0;
            Done     <= 1'b0;
            Busy     <= 1'b0;
            AlignErr <= 1'b0;
        end else begin
            Done     <= 1'b0;
            AlignErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (misaligned) begin
                            // Rejected request: no read, stay idle.
                            AlignErr <= 1'b1;
                        end else begin
                            size_q  <= LCControl;
                            sign_q  <= LCSigned;
`ifdef LOAD_CONTROL_BYTE_LANE_EN
                            lane_q  <= Addr[1:0];
`else
                            lane_q  <= 2'b00;
`endif
                            MemAddr <= {Addr[31:2], 2'b00};
                            MemRead <= 1'b1;
                            Busy    <= 1'b1;
                            count   <= COUNT_INIT;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    if (count == 4'd0) begin
                        mdr     <= MemData;
                        MemRead <= 1'b0;
                        state   <= EXTRACT;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                EXTRACT: begin
                    Out   <= extracted;
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_control.sv
module tb_load_control;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  LCControl;
    logic        LCSigned;
    logic [31:0] Addr;
    logic [31:0] MemData;
    logic        MemRead;
    logic [31:0] MemAddr;
    logic [31:0] Out;
    logic        Done;
    logic        Busy;
    logic        AlignErr;

    load_control #(.MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .Start(Start), .LCControl(LCControl),
        .LCSigned(LCSigned), .Addr(Addr), .MemData(MemData),
        .MemRead(MemRead), .MemAddr(MemAddr), .Out(Out), .Done(Done),
        .Busy(Busy), .AlignErr(AlignErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] out;
        logic [31:0] addr;
        int          done_edge;
    } exp_t;
    exp_t sb[$];

    int          last_k    = -100;
    int          next_free = 0;
    int          err_edge  = -100;
    logic [31:0] cur_data  = 32'h0;
    int          rd_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] ctl, input bit sg,
                                             input logic [31:0] ad, input logic [31:0] d);
        int lane;
        logic [31:0] v;
        lane = 0;
`ifdef LOAD_CONTROL_BYTE_LANE_EN
        lane = int'(ad[1:0]);
`else
        if (ad === 32'hx) lane = 0;
`endif
        if (ctl == 2'b01) begin
            v = (d >> ((lane >= 2) ? 16 : 0)) & 32'h0000FFFF;
            if (sg && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else if (ctl == 2'b10) begin
            v = (d >> (8 * lane)) & 32'h000000FF;
            if (sg && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic bit is_misaligned(input logic [1:0] ctl, input logic [31:0] ad);
`ifdef LOAD_CONTROL_BYTE_LANE_EN
        if (ctl == 2'b01) return ad[0];
        if (ctl == 2'b10) return 1'b0;
        return ad[1:0] != 2'b00;
`else
        return (ctl === 2'bxx) && (ad === 32'hx);
`endif
    endfunction

    // Memory model: data is valid only once MemRead has been high for L cycles.
    always @(negedge clk) begin
        if (MemRead === 1'b1) rd_cnt++;
        else rd_cnt = 0;
        MemData = (rd_cnt == L) ? cur_data : ~cur_data;
    end

    // Monitor: timing of strobes and scoreboard pop on Done.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("busy", {31'd0, Busy}, {31'd0, (cyc >= last_k && cyc <= last_k + L)});
            check("memread", {31'd0, MemRead}, {31'd0, (cyc >= last_k && cyc <= last_k + L - 1)});
            check("alignerr", {31'd0, AlignErr}, {31'd0, (cyc == err_edge)});
            if (Done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done cyc=%0d out=%h", cyc, Out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out", Out, e.out);
                    check("memaddr", MemAddr, e.addr);
                    check("done_time", cyc, e.done_edge);
                    $display("load done cyc=%0d addr=%h out=%h", cyc, MemAddr, Out);
                end
            end
        end
    end

    task automatic issue(input bit st, input logic [1:0] ctl, input bit sg,
                         input logic [31:0] ad, input logic [31:0] dat);
        int edge_i;
        exp_t e;
        @(negedge clk);
        Start = st; LCControl = ctl; LCSigned = sg; Addr = ad;
        edge_i = cyc + 1;
        if (st && edge_i >= next_free) begin
            if (is_misaligned(ctl, ad)) begin
                err_edge  = edge_i;
                next_free = edge_i + 1;
            end else begin
                cur_data  = dat;
                last_k    = edge_i;
                next_free = edge_i + L + 2;
                e.out       = ref_load(ctl, sg, ad, dat);
                e.addr      = {ad[31:2], 2'b00};
                e.done_edge = edge_i + L + 1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || cyc + 1 < next_free) && n < 50) begin
            issue(0, 2'b00, 0, 32'h0, 32'h0);
            n++;
        end
        check("drain_bound", {31'd0, (n < 50)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; Start = 1'b1; LCControl = 2'b00; LCSigned = 1'b0;
        Addr = 32'h0000_0104; MemData = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_out", Out, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_alignerr", {31'd0, AlignErr}, 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        Start = 1'b0;
        reset = 1'b1;
        repeat (5) issue(0, 2'b00, 0, 32'h0, 32'h0);

        // Directed loads.
        issue(1, 2'b00, 0, 32'h0000_0104, 32'hDEADBEEF); wait_idle();
        issue(1, 2'b10, 1, 32'h0000_0100, 32'h123456F0); wait_idle();
        issue(1, 2'b10, 0, 32'h0000_0100, 32'h123456F0); wait_idle();
        issue(1, 2'b01, 1, 32'h0000_0100, 32'h00008001); wait_idle();
        issue(1, 2'b01, 0, 32'h0000_0100, 32'h00008001); wait_idle();
        issue(1, 2'b11, 1, 32'h0000_0200, 32'h80000001); wait_idle();

        // Start while in READ is ignored.
        issue(1, 2'b00, 0, 32'h0000_0040, 32'hCAFEF00D);
        issue(0, 2'b00, 0, 32'h0, 32'h0);
        issue(1, 2'b10, 1, 32'h0000_0080, 32'h11111111);
        wait_idle();

        // Start landing on the EXTRACT cycle is ignored.
        issue(1, 2'b01, 1, 32'h0000_0300, 32'h0000FFFE);
        repeat (L) issue(0, 2'b00, 0, 32'h0, 32'h0);
        issue(1, 2'b00, 0, 32'h0000_0400, 32'h55555555);
        wait_idle();

`ifdef LOAD_CONTROL_BYTE_LANE_EN
        issue(1, 2'b10, 1, 32'h0000_0203, 32'h80FF1122); wait_idle();
        issue(1, 2'b01, 1, 32'h0000_0201, 32'h80FF1122); wait_idle();
        repeat (4) issue(0, 2'b00, 0, 32'h0, 32'h0);
`endif

        // Reset in the middle of READ aborts the load.
        issue(1, 2'b00, 0, 32'h0000_0500, 32'h0BADF00D);
        @(posedge clk);
        #2;
        sb.delete();
        last_k = -100;
        next_free = 0;
        reset = 1'b0;
        Start = 1'b0;
        #1;
        check("abort_memread", {31'd0, MemRead}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) issue(0, 2'b00, 0, 32'h0, 32'h0);

        // Randomised traffic, including Starts that collide with busy cycles.
        for (int i = 0; i < 400; i++) begin
            issue(($urandom % 3) == 0, 2'($urandom), 1'($urandom), $urandom, $urandom);
        end
        wait_idle();
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_control.md
Name: load_control

Overview:
- Read-side counterpart of the store merge path.
- Issues a word read to data memory, waits a fixed memory latency, and latches the returned word into an internal MDR register.
- Extracts the word, halfword or byte, then sign- or zero-extends it to 32 bits for register write-back.
- Sits between the multicycle control unit (Start/Done handshake) and the data memory read port.

Parameters:
- MEM_LATENCY, 2, cycles from MemRead assertion to valid MemData (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle load request pulse from control unit.
- LCControl  input  2  size: 00 word (lw), 01 halfword (lh/lhu), 10 byte (lb/lbu), 11 word.
- LCSigned  input  1  1 = sign-extend, 0 = zero-extend (ignored for word).
- Addr  input  32  byte address of the load.
- MemData  input  32  read data from memory.
- MemRead  output  1  memory read strobe.
- MemAddr  output  32  word-aligned address, {Addr[31:2],2'b00}.
- Out  output  32  extended load result.
- Done  output  1  one-cycle pulse; Out valid.
- Busy  output  1  high while a load is in flight.
- AlignErr  output  1  one-cycle pulse on misaligned access (feature-dependent).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; MemRead=0, MemAddr=0, Out=0, Done=0, Busy=0, AlignErr=0; internal MDR=0, counter=0.
- Reset mid-operation aborts the load; no Done is produced.
- FSM states: IDLE, READ, EXTRACT.
- IDLE:
  - Start=1 at edge k latches Addr, LCControl and LCSigned.
  - Sets MemAddr, MemRead=1, Busy=1, counter=MEM_LATENCY-1, then moves to READ.
- READ:
  - MemRead stays high.
  - When counter=0, MemData is latched into MDR at that edge (edge k+MEM_LATENCY), MemRead drops, and the FSM moves to EXTRACT.
  - Otherwise the counter decrements.
- EXTRACT:
  - Out is registered from MDR per size/sign; Done=1 for exactly one cycle (cycle k+MEM_LATENCY+1).
  - Busy drops in the same cycle, then the FSM returns to IDLE.
- Total latency: Start edge to Done = MEM_LATENCY+1 cycles.
- Extraction, default lane (no feature):
  - byte = MDR[7:0], half = MDR[15:0], word = MDR.
  - Sign extension replicates bit 7 / bit 15 when LCSigned=1; otherwise the upper bits are zero.
- Out holds its value until the next Done. MemAddr holds its value until the next Start is accepted.
- Start while Busy=1 is ignored; no queueing.
- Start in the same cycle as the EXTRACT state is ignored, because Busy is still high.
- LCControl=11 behaves exactly as 00.
- Without the feature, AlignErr is always 0 and Addr[1:0] is ignored.

Optional Feature:
- Macro: LOAD_CONTROL_BYTE_LANE_EN.
- When defined, Addr[1:0] selects the little-endian lane:
  - byte from MDR[8*Addr[1:0]+7 : 8*Addr[1:0]].
  - half from MDR[31:16] when Addr[1]=1, else MDR[15:0].
- A misaligned access is a half with Addr[0]=1, or a word with Addr[1:0]≠0. On a misaligned Start:
  - No memory read is issued.
  - AlignErr pulses 1 cycle after the Start edge and the FSM stays in IDLE.
  - Done is not asserted and Out is unchanged.
- When not defined, low-lane extraction is used (matching the store merge path) and AlignErr is tied 0.

Test Plan:
- Reset and idle: reset low with Start=1 → MemRead=0, Out=0, Done=0, Busy=0; after release, idle 5 cycles with no Done.
- lw with MEM_LATENCY=2: Addr=0x00000104, MemData=0xDEADBEEF → MemAddr=0x104, MemRead high 2 cycles, Done 3 cycles after Start, Out=0xDEADBEEF.
- lb signed vs unsigned: MemData=0x123456F0 → LCSigned=1 gives Out=0xFFFFFFF0; LCSigned=0 gives Out=0x000000F0.
- lh signed: MemData=0x00008001 → Out=0xFFFF8001; with LCSigned=0 → Out=0x00008001.
- Start while Busy, then reset mid-READ:
  - A second Start in the READ state → ignored; exactly one Done.
  - reset driven low during READ → MemRead=0 immediately, no Done afterwards.
- With LOAD_CONTROL_BYTE_LANE_EN:
  - lb Addr=0x203, MemData=0x80FF1122, LCSigned=1 → Out=0xFFFFFF80.
  - lh Addr=0x201 → AlignErr pulse, MemRead never asserted, no Done.
